// File: rtl/siso_shift_ctrl_if.sv
// Handshake bundle between the parallel word producer, the shift controller
// and the serial bit consumer.
interface siso_shift_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic             out_last;

  // Producer/consumer side: offers words, accepts bits
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bit,
    input  out_last
  );

  // Controller side
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bit,
    output out_last
  );
endinterface

// File: rtl/siso_shift_ctrl.sv
// Frame controller for an LSB-first serial shifter: loads a parallel word,
// emits one bit per accepted transfer, then idles for GAP cycles.
// All outputs come straight from flops; next values are computed once in
// the next-state block and registered alongside the state.
module siso_shift_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  siso_shift_ctrl_if.slave bus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_count
);

  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam int unsigned GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [BW-1:0]    bcnt, bcnt_nxt;
  logic [GW-1:0]    gcnt, gcnt_nxt;
  logic             done_nxt;
  logic [CNT_W-1:0] fcnt_nxt;

  // Next-state, datapath and frame bookkeeping
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    bcnt_nxt  = bcnt;
    gcnt_nxt  = gcnt;
    done_nxt  = 1'b0;
    fcnt_nxt  = frame_count;
    unique case (state)
      ST_IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          shreg_nxt = bus.in_data;
          bcnt_nxt  = BW'(WIDTH);
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.out_valid && bus.out_ready) begin
          shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
          bcnt_nxt  = bcnt - BW'(1);
          if (bcnt == BW'(1)) begin
            done_nxt = 1'b1;
            fcnt_nxt = frame_count + CNT_W'(1);
            if (GAP > 0) begin
              state_nxt = ST_GAP;
              gcnt_nxt  = GW'(GAP);
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        gcnt_nxt = gcnt - GW'(1);
        if (gcnt <= GW'(1)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      shreg <= '0;
      bcnt  <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      bcnt  <= bcnt_nxt;
      gcnt  <= gcnt_nxt;
    end
  end

  // Registered outputs, decoded from the next-state values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_bit   <= 1'b0;
      bus.out_last  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      frame_count   <= '0;
    end else begin
      bus.in_ready  <= (state_nxt == ST_IDLE);
      bus.out_valid <= (state_nxt == ST_SHIFT);
      bus.out_bit   <= (state_nxt == ST_SHIFT) && shreg_nxt[0];
      bus.out_last  <= (state_nxt == ST_SHIFT) && (bcnt_nxt == BW'(1));
      busy          <= (state_nxt != ST_IDLE);
      done          <= done_nxt;
      frame_count   <= fcnt_nxt;
    end
  end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Bench for siso_shift_ctrl: one instance with GAP=1/CNT_W=16 and one with
// GAP=0/CNT_W=3 (so the frame counter wraps quickly). Expected outputs come
// from a frame-level model: a queue of pending serial bits plus the number
// of cycles since the last frame ended.
`timescale 1ns/1ps
module tb_siso_shift_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned OW = 22;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  siso_shift_ctrl_if #(.WIDTH(W)) bus1 ();
  siso_shift_ctrl_if #(.WIDTH(W)) bus0 ();

  logic        busy1, done1;
  logic [15:0] fc1;
  logic        busy0, done0;
  logic [2:0]  fc0;

  siso_shift_ctrl #(.WIDTH(W), .GAP(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .busy(busy1), .done(done1), .frame_count(fc1)
  );

  siso_shift_ctrl #(.WIDTH(W), .GAP(0), .CNT_W(3)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .busy(busy0), .done(done0), .frame_count(fc0)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Frame-level reference model
  bit         exp_q[$];
  bit         got_q[$];
  int         acc_cyc[$];
  logic [7:0] acc_word[$];
  int         t_since;
  int         exp_fc;
  int         gap_m;
  int         mod_m;

  task automatic model_reset(input bit which);
    exp_q.delete();
    got_q.delete();
    acc_cyc.delete();
    acc_word.delete();
    t_since = 100;
    exp_fc  = 0;
    gap_m   = which ? 1 : 0;
    mod_m   = which ? 65536 : 8;
  endtask

  // {in_ready, out_valid, out_bit, out_last, busy, done, frame_count}
  function automatic logic [OW-1:0] exp_vec();
    logic ir, ov, ob, ol;
    ir = (exp_q.size() == 0) && (t_since > gap_m);
    ov = (exp_q.size() != 0);
    ob = ov ? exp_q[0] : 1'b0;
    ol = (exp_q.size() == 1);
    return {ir, ov, ob, ol, ~ir, (t_since == 1), 16'(exp_fc)};
  endfunction

  task automatic sample(input bit which, output logic [OW-1:0] v);
    if (which)
      v = {bus1.in_ready, bus1.out_valid, bus1.out_valid & bus1.out_bit,
           bus1.out_last, busy1, done1, fc1};
    else
      v = {bus0.in_ready, bus0.out_valid, bus0.out_valid & bus0.out_bit,
           bus0.out_last, busy0, done0, 16'(fc0)};
  endtask

  task automatic drive(input bit which, input logic iv, input logic [7:0] id, input logic ordy);
    if (which) begin
      bus1.in_valid = iv; bus1.in_data = id; bus1.out_ready = ordy;
    end else begin
      bus0.in_valid = iv; bus0.in_data = id; bus0.out_ready = ordy;
    end
  endtask

  // Advance one cycle to the falling edge and fetch observed/expected
  task automatic step(input bit which, output logic [OW-1:0] o, output logic [OW-1:0] e);
    @(negedge clk);
    cyc++;
    if (t_since < 1000) t_since++;
    sample(which, o);
    e = exp_vec();
  endtask

  // Drive inputs for the coming edge and update the model with its effect
  task automatic apply_inputs(input bit which, input logic iv, input logic [7:0] id, input logic ordy);
    bit ir, ov, b;
    drive(which, iv, id, ordy);
    ir = (exp_q.size() == 0) && (t_since > gap_m);
    ov = (exp_q.size() != 0);
    if (ov && ordy) begin
      b = exp_q.pop_front();
      got_q.push_back(b);
      if (exp_q.size() == 0) begin
        t_since = 0;
        exp_fc  = (exp_fc + 1) % mod_m;
      end
    end
    if (ir && iv) begin
      for (int i = 0; i < 8; i++) exp_q.push_back(id[i]);
      acc_cyc.push_back(cyc);
      acc_word.push_back(id);
    end
  endtask

  function automatic logic [7:0] got_byte(input int off);
    logic [7:0] b;
    for (int i = 0; i < 8; i++)
      b[i] = (off + i < got_q.size()) ? got_q[off + i] : 1'bx;
    return b;
  endfunction

  task automatic apply_reset(input bit which);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset(which);
  endtask

  task automatic test_reset();
    logic [OW-1:0] o, e;
    apply_reset(1'b1);
    for (int c = 0; c < 4; c++) begin
      step(1'b1, o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL reset_pre cyc=%0d got=%h exp=%h", cyc, o, e); end
      apply_inputs(1'b1, (c == 0), 8'h5A, 1'b1);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus1.in_ready, bus1.out_valid, bus1.out_bit, bus1.out_last, busy1, done1, fc1} !== {6'b100000, 16'h0}) begin
      bad++;
      $display("FAIL reset_async got=%b exp=%b", {bus1.in_ready, bus1.out_valid, bus1.out_bit, bus1.out_last, busy1, done1, fc1}, {6'b100000, 16'h0});
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset(1'b1);
    for (int c = 0; c < 4; c++) begin
      step(1'b1, o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, o, e); end
      apply_inputs(1'b1, 1'b0, 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_single();
    logic [OW-1:0] o, e;
    int dones = 0, lasts = 0, last_cyc = -1, ready_cyc = -1;
    apply_reset(1'b1);
    for (int c = 0; c < 14; c++) begin
      step(1'b1, o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL single cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (o[16]) dones++;
      if (o[18]) begin lasts++; last_cyc = cyc; end
      if (acc_cyc.size() > 0 && cyc > acc_cyc[0] && o[21] && ready_cyc < 0) ready_cyc = cyc;
      apply_inputs(1'b1, (acc_word.size() == 0), 8'hA5, 1'b1);
    end
    total++;
    if (got_byte(0) !== 8'hA5 || got_q.size() != 8) begin
      bad++; $display("FAIL single_bits got=%h n=%0d exp=a5 n=8", got_byte(0), got_q.size());
    end
    total++;
    if (dones != 1 || fc1 !== 16'd1) begin
      bad++; $display("FAIL single_done dones=%0d fc=%0d exp 1/1", dones, fc1);
    end
    total++;
    if (lasts != 1 || last_cyc != acc_cyc[0] + 8) begin
      bad++; $display("FAIL single_last n=%0d at=%0d exp n=1 at=%0d", lasts, last_cyc, acc_cyc[0] + 8);
    end
    total++;
    if (ready_cyc != acc_cyc[0] + 10) begin
      bad++; $display("FAIL single_ready at=%0d exp=%0d", ready_cyc, acc_cyc[0] + 10);
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] o, e;
    logic ordy;
    int stalls = 0, done_cyc = -1;
    apply_reset(1'b1);
    for (int c = 0; c < 22; c++) begin
      step(1'b1, o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL backpressure cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (o[16] && done_cyc < 0) done_cyc = cyc;
      ordy = 1'b1;
      if (got_q.size() == 2 && stalls < 3) begin ordy = 1'b0; stalls++; end
      apply_inputs(1'b1, (acc_word.size() == 0), 8'hA5, ordy);
    end
    total++;
    if (got_byte(0) !== 8'hA5 || got_q.size() != 8) begin
      bad++; $display("FAIL bp_bits got=%h n=%0d exp=a5 n=8", got_byte(0), got_q.size());
    end
    total++;
    if (done_cyc != acc_cyc[0] + 12) begin
      bad++; $display("FAIL bp_done at=%0d exp=%0d", done_cyc, acc_cyc[0] + 12);
    end
  endtask

  task automatic test_ignored();
    logic [OW-1:0] o, e;
    apply_reset(1'b1);
    for (int c = 0; c < 25; c++) begin
      step(1'b1, o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL ignored cyc=%0d got=%h exp=%h", cyc, o, e); end
      apply_inputs(1'b1, 1'b1, (acc_word.size() == 0) ? 8'hA5 : 8'hFF, 1'b1);
    end
    total++;
    if (acc_word.size() < 2 || got_byte(0) !== 8'hA5 || got_byte(8) !== 8'hFF) begin
      bad++; $display("FAIL ignored_stream got=%h,%h exp=a5,ff", got_byte(0), got_byte(8));
    end
    total++;
    if (acc_cyc.size() < 2 || acc_cyc[1] - acc_cyc[0] != 10) begin
      bad++; $display("FAIL ignored_spacing accepts=%0d exp spacing 10", acc_cyc.size());
    end
  endtask

  task automatic test_abort();
    logic [OW-1:0] o, e;
    bit reached = 1'b0;
    apply_reset(1'b1);
    for (int c = 0; c < 40 && !reached; c++) begin
      step(1'b1, o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL abort_pre cyc=%0d got=%h exp=%h", cyc, o, e); end
      apply_inputs(1'b1, (acc_word.size() < 2), (acc_word.size() == 0) ? 8'hA5 : 8'h3C, 1'b1);
      if (got_q.size() == 11) reached = 1'b1;
    end
    total++;
    if (!reached || fc1 !== 16'd1) begin
      bad++; $display("FAIL abort_setup reached=%0d fc=%0d exp 1/1", reached, fc1);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus1.out_valid, busy1, done1, fc1} !== {3'b000, 16'h0}) begin
      bad++; $display("FAIL abort_async got=%b exp=%b", {bus1.out_valid, busy1, done1, fc1}, {3'b000, 16'h0});
    end
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    total++;
    if (done1 !== 1'b0) begin bad++; $display("FAIL abort_nodone got=%b exp=0", done1); end
    rst = 1'b0;
    model_reset(1'b1);
    for (int c = 0; c < 14; c++) begin
      step(1'b1, o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL abort_post cyc=%0d got=%h exp=%h", cyc, o, e); end
      apply_inputs(1'b1, (acc_word.size() == 0), 8'h81, 1'b1);
    end
    total++;
    if (got_byte(0) !== 8'h81 || fc1 !== 16'd1) begin
      bad++; $display("FAIL abort_new got=%h fc=%0d exp=81 fc=1", got_byte(0), fc1);
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] o, e;
    int dones;
    for (int k = 0; k < 2; k++) begin
      bit w = (k == 0);
      dones = 0;
      apply_reset(w);
      for (int c = 0; c < 26; c++) begin
        step(w, o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL b2b w=%0d cyc=%0d got=%h exp=%h", w, cyc, o, e); end
        if (o[16]) dones++;
        apply_inputs(w, (acc_word.size() < 2), (acc_word.size() == 0) ? 8'h01 : 8'h80, 1'b1);
      end
      total++;
      if (acc_cyc.size() < 2 || acc_cyc[1] - acc_cyc[0] != (w ? 10 : 9)) begin
        bad++; $display("FAIL b2b_spacing w=%0d accepts=%0d exp spacing %0d", w, acc_cyc.size(), w ? 10 : 9);
      end
      total++;
      if (got_byte(0) !== 8'h01 || got_byte(8) !== 8'h80) begin
        bad++; $display("FAIL b2b_bits w=%0d got=%h,%h exp=01,80", w, got_byte(0), got_byte(8));
      end
      total++;
      if (dones != 2 || o[15:0] !== 16'd2) begin
        bad++; $display("FAIL b2b_count w=%0d dones=%0d fc=%0d exp 2/2", w, dones, o[15:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] o, e;
    for (int k = 0; k < 2; k++) begin
      bit w = (k == 0);
      apply_reset(w);
      for (int c = 0; c < 500; c++) begin
        step(w, o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL random w=%0d cyc=%0d got=%h exp=%h", w, cyc, o, e); end
        apply_inputs(w, 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));
      end
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    model_reset(1'b1);
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_ignored();
    test_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
